writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Consumer end of the unit writeback interface.
- Collects finished results (`done`, `rd`, `id`) from NUM_UNITS execution units, e.g. ALU, MUL, DIV, load/store, CSR.
- Grants one unit per cycle by round-robin and acknowledges the granted unit.
- Holds the selected result in a registered output stage with valid/ready toward the register-file write port and the instruction-ID retire logic.

Parameters:
- NUM_UNITS, 4, number of writeback sources (1..8)
- XLEN, 32, result data width
- ID_WIDTH, 3, instruction ID width (`id_t` width)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- unit_done  in  NUM_UNITS  per-unit result valid; held until acknowledged
- unit_rd  in  NUM_UNITS x XLEN  per-unit result data
- unit_id  in  NUM_UNITS x ID_WIDTH  per-unit instruction ID
- unit_ack  out  NUM_UNITS  one-hot; result taken this cycle
- wb_valid  out  1  output packet valid
- wb_ready  in  1  downstream accepts packet this cycle
- wb_data  out  XLEN  selected result
- wb_id  out  ID_WIDTH  selected instruction ID
- wb_unit  out  clog2(NUM_UNITS) (min 1)  index of granting unit, for debug/perf

Behaviour:
- Reset (synchronous, active-high; rst sampled on posedge clk):
  - wb_valid=0, wb_data=0, wb_id=0, wb_unit=0, RR pointer=0.
  - unit_ack is all-zero during any cycle rst=1.
- Output register states: EMPTY (wb_valid=0) and FULL (wb_valid=1).
  - load = (|unit_done) & (~wb_valid | wb_ready).
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on wb_ready & no request.
  - FULL -> FULL on (~wb_ready), or on wb_ready with load (drain and refill in the same cycle, so throughput is 1/cycle).
- Grant:
  - Scan unit_done starting at the RR pointer, ascending, wrapping modulo NUM_UNITS; the first asserted bit wins.
  - unit_ack[g] = load & (grant==g); combinational and same cycle as the load.
  - On ack, the pointer becomes (g+1) mod NUM_UNITS; otherwise it holds.
- Latency: unit_done at cycle t with output EMPTY gives wb_valid/wb_data/wb_id at t+1.
- Backpressure: while FULL & ~wb_ready:
  - wb_data, wb_id, wb_unit are stable;
  - no ack is issued;
  - the pointer is frozen.
- Units must hold done/rd/id stable until acked.
  - Single-cycle units such as the ALU assert done unconditionally and rely on the issue stall.
  - The arbiter does not latch unacked requests.
- Simultaneous requests from all units with wb_ready=1 every cycle: grant order is p, p+1, ..., wrapping. No unit waits more than NUM_UNITS-1 grants.
- Wrap-around: a grant to unit NUM_UNITS-1 sets the pointer to 0.
- NUM_UNITS=1: grant is always 0 and the pointer is a constant; the block reduces to a one-entry valid/ready register.
- Reset mid-operation: any FULL packet is discarded and is not presented after reset; no ack is issued in the reset cycle.
- Assertions:
  - unit_ack is one-hot or zero.
  - wb_data and wb_id are stable while wb_valid & ~wb_ready.
  - No ack while rst.

Optional Feature:
- Macro: WB_ARB_UNIT0_PRIORITY_EN.
- Defined: unit 0 (ALU) wins whenever unit_done[0]=1, regardless of the pointer. The pointer is not advanced on unit-0 grants. Other units are arbitrated round-robin among themselves.
- Undefined: pure round-robin across all units, including unit 0.

Decomposition:
- Shared package (cva5_types):
  - `wb_packet_t` struct {data[XLEN], id[ID_WIDTH]};
  - `localparam WB_UNIT_W = $clog2(NUM_UNITS)`, minimum 1.
- Sub-module rr_arbiter:
  - parameter N; inputs request[N], advance; outputs grant_onehot[N], grant_idx;
  - holds the pointer register (clk, rst inside).
  - The top level holds the output register, load logic, data mux and the optional priority override.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, unit_done=0 -> wb_valid=0, unit_ack=0, wb_data=0 throughout.
- Single request: unit 2 done with rd=0xDEADBEEF, id=5, wb_ready=1 -> unit_ack=4'b0100 the same cycle; next cycle wb_valid=1, wb_data=0xDEADBEEF, wb_id=5, wb_unit=2.
- Fairness: all four units done continuously, wb_ready=1, pointer=0 -> grants 0,1,2,3,0,1 on consecutive cycles; one ack per cycle.
- Backpressure: output FULL with id=1, wb_ready=0 for 3 cycles while units 1 and 3 request -> no acks and wb_id stays 1; wb_ready=1 -> same-cycle refill with unit 1, then unit 3.
- Reset mid-flight: FULL packet id=6 and rst asserted -> next cycle wb_valid=0 and pointer=0; the packet is never presented.
- With WB_ARB_UNIT0_PRIORITY_EN: units 0 and 1 done continuously -> unit 0 granted every cycle. Remove unit 0 -> unit 1 granted next cycle. Without the macro -> grants alternate 0,1,0,1.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared types and sizing helpers for the unit writeback arbiter.
package writeback_arbiter_pkg;

  // Default build parameters of the writeback path.
  localparam int unsigned DEF_NUM_UNITS = 4;
  localparam int unsigned DEF_XLEN      = 32;
  localparam int unsigned DEF_ID_WIDTH  = 3;

  // Index width for n sources; a single source still needs one bit.
  function automatic int unsigned unit_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned WB_UNIT_W = unit_idx_w(DEF_NUM_UNITS);

  // Result packet handed to the register-file write port and retire logic.
  typedef struct packed {
    logic [DEF_XLEN-1:0]     data;
    logic [DEF_ID_WIDTH-1:0] id;
  } wb_packet_t;

endpackage

// File: rtl/writeback_arbiter_rr.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// wrapping; the pointer moves past the winner only when told to advance.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     request,
  input  logic             advance,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Winner is the lowest request at/above the pointer, else the lowest overall.
  always_comb begin
    hi_found     = 1'b0;
    lo_found     = 1'b0;
    hi_idx       = '0;
    lo_idx       = '0;
    grant_onehot = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (request[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
      if (request[i] && !hi_found && (IDX_W'(i) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < int'(N); i++) begin
      grant_onehot[i] = lo_found && (grant_idx == IDX_W'(i));
    end
  end

  // Next pointer: one past the winner, wrapping to zero after the last unit.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && lo_found) begin
      ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: picks one finished execution-unit result per cycle
// (round-robin), acknowledges it, and holds it in a valid/ready output stage.
// Optional macro WB_ARB_UNIT0_PRIORITY_EN: unit 0 wins whenever it requests,
// without moving the round-robin pointer; the others rotate among themselves.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_UNITS = DEF_NUM_UNITS,
  parameter  int unsigned XLEN      = DEF_XLEN,
  parameter  int unsigned ID_WIDTH  = DEF_ID_WIDTH,
  localparam int unsigned UNIT_W    = unit_idx_w(NUM_UNITS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_UNITS-1:0]               unit_done,
  input  logic [NUM_UNITS-1:0][XLEN-1:0]     unit_rd,
  input  logic [NUM_UNITS-1:0][ID_WIDTH-1:0] unit_id,
  output logic [NUM_UNITS-1:0]               unit_ack,
  output logic                               wb_valid,
  input  logic                               wb_ready,
  output logic [XLEN-1:0]                    wb_data,
  output logic [ID_WIDTH-1:0]                wb_id,
  output logic [UNIT_W-1:0]                  wb_unit
);

  typedef struct packed {
    logic [XLEN-1:0]     data;
    logic [ID_WIDTH-1:0] id;
  } wb_pkt_t;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]           state_q;
  logic [0:0]           state_d;
  wb_pkt_t              pkt_q;
  wb_pkt_t              pkt_d;
  logic [UNIT_W-1:0]    unit_q;
  logic [UNIT_W-1:0]    unit_d;

  logic [NUM_UNITS-1:0] rr_req;
  logic [NUM_UNITS-1:0] rr_onehot;
  logic [UNIT_W-1:0]    rr_idx;
  logic                 rr_adv;
  logic [NUM_UNITS-1:0] gnt_onehot_c;
  logic [UNIT_W-1:0]    gnt_idx_c;
  logic                 unit0_win_c;
  logic                 load_c;
  wb_pkt_t              sel_pkt_c;

`ifdef WB_ARB_UNIT0_PRIORITY_EN
  assign rr_req = unit_done & ~NUM_UNITS'(1);
`else
  assign rr_req = unit_done;
`endif

  rr_arbiter #(
    .N     (NUM_UNITS),
    .IDX_W (UNIT_W)
  ) u_rr (
    .clk          (clk),
    .rst          (rst),
    .request      (rr_req),
    .advance      (rr_adv),
    .grant_onehot (rr_onehot),
    .grant_idx    (rr_idx)
  );

  // Final grant: round-robin winner, optionally overridden by unit 0.
  always_comb begin
    gnt_onehot_c = rr_onehot;
    gnt_idx_c    = rr_idx;
    unit0_win_c  = 1'b0;
`ifdef WB_ARB_UNIT0_PRIORITY_EN
    unit0_win_c = unit_done[0];
    if (unit0_win_c) begin
      gnt_onehot_c = NUM_UNITS'(1);
      gnt_idx_c    = '0;
    end
`endif
  end

  // Take a result when something is done and the output slot is free or draining.
  assign wb_valid = (state_q == ST_FULL);
  assign load_c   = (|unit_done) && (!wb_valid || wb_ready);
  assign unit_ack = (load_c && !rst) ? gnt_onehot_c : '0;
  assign rr_adv   = load_c && !rst && !unit0_win_c;

  // AND-OR mux of the granted unit's result.
  always_comb begin
    sel_pkt_c = '0;
    for (int i = 0; i < int'(NUM_UNITS); i++) begin
      if (gnt_onehot_c[i]) begin
        sel_pkt_c.data = sel_pkt_c.data | unit_rd[i];
        sel_pkt_c.id   = sel_pkt_c.id | unit_id[i];
      end
    end
  end

  // Output stage next state: fill on load, drain on ready, refill while draining.
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    unit_d  = unit_q;
    case (state_q)
      ST_EMPTY: begin
        if (load_c) begin
          state_d = ST_FULL;
          pkt_d   = sel_pkt_c;
          unit_d  = gnt_idx_c;
        end
      end
      ST_FULL: begin
        if (wb_ready) begin
          if (load_c) begin
            pkt_d  = sel_pkt_c;
            unit_d = gnt_idx_c;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output stage registers; reset discards any held packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      pkt_q   <= '0;
      unit_q  <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      unit_q  <= unit_d;
    end
  end

  assign wb_data = pkt_q.data;
  assign wb_id   = pkt_q.id;
  assign wb_unit = unit_q;

  // Interface invariants.
  a_ack_onehot : assert property (@(posedge clk) $onehot0(unit_ack));
  a_no_ack_rst : assert property (@(posedge clk) rst |-> (unit_ack == '0));
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
                   (wb_valid && !wb_ready) |=> ($stable(wb_data) && $stable(wb_id)));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a queue-free reference model
// (modular round-robin scan) checked every cycle, plus literal expectations.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int XW = 32;
  localparam int IW = 3;
  localparam int UW = WB_UNIT_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         unit_done = '0;
  logic [N-1:0][XW-1:0] unit_rd;
  logic [N-1:0][IW-1:0] unit_id;
  logic [N-1:0]         unit_ack;
  logic                 wb_valid;
  logic                 wb_ready = 1'b1;
  logic [XW-1:0]        wb_data;
  logic [IW-1:0]        wb_id;
  logic [UW-1:0]        wb_unit;

  int checks = 0;
  int errors = 0;

  writeback_arbiter #(.NUM_UNITS(N), .XLEN(XW), .ID_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .unit_done (unit_done),
    .unit_rd   (unit_rd),
    .unit_id   (unit_id),
    .unit_ack  (unit_ack),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_id     (wb_id),
    .wb_unit   (wb_unit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       m_valid = 1'b0;
  wb_packet_t m_pkt = '0;
  int         m_unit = 0;
  int         m_ptr = 0;
  logic       armed = 1'b0;
  int         m_g;
  logic       m_load;
  logic [N-1:0] m_exp_ack;

  // Which unit the rules say wins now, and whether it is taken this cycle.
  always_comb begin
    int u;
    u = 0;
    m_g = -1;
`ifdef WB_ARB_UNIT0_PRIORITY_EN
    if (unit_done[0]) m_g = 0;
`endif
    for (int k = 0; k < N; k++) begin
      u = (m_ptr + k) % N;
`ifdef WB_ARB_UNIT0_PRIORITY_EN
      if (m_g < 0 && u != 0 && unit_done[u[UW-1:0]]) m_g = u;
`else
      if (m_g < 0 && unit_done[u[UW-1:0]]) m_g = u;
`endif
    end
    m_load = !rst && (m_g >= 0) && (!m_valid || wb_ready);
    m_exp_ack = '0;
    if (m_load) m_exp_ack[m_g[UW-1:0]] = 1'b1;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_pkt   <= '0;
      m_unit  <= 0;
      m_ptr   <= 0;
      armed   <= 1'b1;
    end else if (m_load) begin
      m_valid    <= 1'b1;
      m_pkt.data <= unit_rd[m_g[UW-1:0]];
      m_pkt.id   <= unit_id[m_g[UW-1:0]];
      m_unit     <= m_g;
`ifdef WB_ARB_UNIT0_PRIORITY_EN
      if (m_g != 0) m_ptr <= (m_g + 1) % N;
`else
      m_ptr <= (m_g + 1) % N;
`endif
    end else if (wb_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      check("m_ack",   64'(unit_ack), 64'(m_exp_ack));
      check("m_valid", 64'(wb_valid), 64'(m_valid));
      check("m_data",  64'(wb_data),  64'(m_pkt.data));
      check("m_id",    64'(wb_id),    64'(m_pkt.id));
      check("m_unit",  64'(wb_unit),  64'(m_unit));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic [N-1:0] d, input logic rdy);
    @(posedge clk);
    #1;
    rst       = r;
    unit_done = d;
    wb_ready  = rdy;
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] fair_exp [6];
    logic [N-1:0] alt_exp  [4];
`ifdef WB_ARB_UNIT0_PRIORITY_EN
    fair_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    alt_exp  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    alt_exp  = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
    for (int u = 0; u < N; u++) begin
      unit_rd[u] = 32'h1000_0000 + 32'(u);
      unit_id[u] = IW'(u);
    end

    // Reset then idle.
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 4'b0000, 1'b1);
      check("rst_valid", 64'(wb_valid), 64'd0);
      check("rst_ack",   64'(unit_ack), 64'd0);
      check("rst_data",  64'(wb_data),  64'd0);
    end
    cyc(1'b0, 4'b0000, 1'b1);
    check("idle_valid", 64'(wb_valid), 64'd0);

    // Single request from unit 2.
    unit_rd[2] = 32'hDEADBEEF;
    unit_id[2] = 3'd5;
    cyc(1'b0, 4'b0100, 1'b1);
    check("single_ack", 64'(unit_ack), 64'b0100);
    cyc(1'b0, 4'b0000, 1'b1);
    check("single_valid", 64'(wb_valid), 64'd1);
    check("single_data",  64'(wb_data),  64'hDEADBEEF);
    check("single_id",    64'(wb_id),    64'd5);
    check("single_unit",  64'(wb_unit),  64'd2);

    // Fairness from pointer 0 with all units requesting.
    cyc(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 4'b1111, 1'b1);
      check("fair_ack", 64'(unit_ack), 64'(fair_exp[i]));
    end

    // Backpressure: hold id=1 while units 1 and 3 wait.
    cyc(1'b1, 4'b0000, 1'b1);
    unit_id[0] = 3'd1;
    unit_id[1] = 3'd2;
    unit_id[3] = 3'd4;
    cyc(1'b0, 4'b0001, 1'b1);
    check("bp_load_ack", 64'(unit_ack), 64'b0001);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b1010, 1'b0);
      check("bp_no_ack", 64'(unit_ack), 64'd0);
      check("bp_hold_id", 64'(wb_id), 64'd1);
      check("bp_hold_valid", 64'(wb_valid), 64'd1);
    end
    cyc(1'b0, 4'b1010, 1'b1);
    check("bp_refill_u1", 64'(unit_ack), 64'b0010);
    cyc(1'b0, 4'b1000, 1'b1);
    check("bp_refill_u3", 64'(unit_ack), 64'b1000);
    check("bp_id_u1", 64'(wb_id), 64'd2);
    cyc(1'b0, 4'b0000, 1'b1);
    check("bp_id_u3", 64'(wb_id), 64'd4);
    check("bp_unit_u3", 64'(wb_unit), 64'd3);
    cyc(1'b0, 4'b0000, 1'b1);
    check("bp_drained", 64'(wb_valid), 64'd0);

    // Reset mid-flight discards the held packet and rewinds the pointer.
    unit_id[2] = 3'd6;
    cyc(1'b0, 4'b0100, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    check("mid_full_id", 64'(wb_id), 64'd6);
    cyc(1'b1, 4'b0100, 1'b0);
    check("mid_rst_ack", 64'(unit_ack), 64'd0);
    cyc(1'b0, 4'b0000, 1'b1);
    check("mid_discard", 64'(wb_valid), 64'd0);
    cyc(1'b0, 4'b1111, 1'b1);
    check("mid_ptr0", 64'(unit_ack), 64'b0001);
    cyc(1'b0, 4'b0000, 1'b1);
    check("mid_unit0", 64'(wb_unit), 64'd0);

    // Units 0 and 1 together, then unit 1 alone.
    cyc(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'b0011, 1'b1);
      check("alt_ack", 64'(unit_ack), 64'(alt_exp[i]));
    end
    cyc(1'b0, 4'b0010, 1'b1);
    check("alt_u1", 64'(unit_ack), 64'b0010);
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
